data_mem_responder: RTL

Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready request channel and returns read data or completion on a valid/ready response channel. It owns a word-organised data RAM. It handles the RV32I access widths LB/LH/LW/LBU/LHU/SB/SH/SW, including byte-lane selection, sign/zero extension and byte-masked writes. Programmable wait states model slow memory so that the core's load/store sequencing can be exercised.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/lsu_align.sv | 85 ++++++++
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: RV32I load/store funct3 codes, the responder FSM state enum,
// and the byte-lane write-mask type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } mem_state_t;

  typedef logic [LANES-1:0] byte_mask_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory port bundle: valid/ready request channel (core -> memory)
// and valid/ready response channel (memory -> core).
//   master : core side, drives request fields and rsp_ready
//   slave  : memory side, drives req_ready and response fields
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for RV32I loads and stores.
// Ports:
//   we           : 1 = store, 0 = load
//   addr_lo      : byte offset within the word
//   funct3       : access width / extension code
//   rword        : word read from the array (load path)
//   wdata        : LSB-aligned store data
//   load_data_c  : extracted and extended load result
//   mask_c       : byte-lane write mask
//   store_data_c : store data replicated onto every lane
//   err_c        : misaligned access or illegal funct3
module lsu_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data_c,
  output byte_mask_t  mask_c,
  output logic [31:0] store_data_c,
  output logic        err_c
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane selection for loads
  always_comb begin
    lane_byte = 8'(rword >> {addr_lo, 3'b000});
    lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Load extension
  always_comb begin
    load_data_c = '0;
    unique case (funct3)
      F3_B:    load_data_c = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data_c = {24'd0, lane_byte};
      F3_H:    load_data_c = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data_c = {16'd0, lane_half};
      F3_W:    load_data_c = rword;
      default: load_data_c = '0;
    endcase
  end

  // Store mask and lane replication
  always_comb begin
    mask_c       = '0;
    store_data_c = '0;
    unique case (funct3)
      F3_B: begin
        mask_c       = byte_mask_t'(4'b0001 << addr_lo);
        store_data_c = {4{wdata[7:0]}};
      end
      F3_H: begin
        mask_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data_c = {2{wdata[15:0]}};
      end
      F3_W: begin
        mask_c       = 4'b1111;
        store_data_c = wdata;
      end
      default: begin
        mask_c       = '0;
        store_data_c = '0;
      end
    endcase
  end

  // Alignment and funct3 legality; unsigned variants exist for loads only
  always_comb begin
    err_c = 1'b1;
    unique case (funct3)
      F3_B:    err_c = 1'b0;
      F3_BU:   err_c = we;
      F3_H:    err_c = addr_lo[0];
      F3_HU:   err_c = we | addr_lo[0];
      F3_W:    err_c = (addr_lo != 2'b00);
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port. Accepts one load/store at a
// time, waits WAIT_CYCLES to model slow memory, accesses a word-organised
// RAM with byte-lane masking, then holds the response until accepted.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : request/response channels (slave side)
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  idx_c;
  logic [31:0]       rword_c;
  logic [31:0]       load_data_c;
  byte_mask_t        mask_c;
  logic [31:0]       store_data_c;
  logic              align_err_c;
  logic              range_err_c;
  logic              acc_err_c;
  logic              mem_we_c;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Array addressing and error classification of the latched request
  always_comb begin
    idx_c       = addr_q[ADDR_WIDTH-1:2];
    rword_c     = mem[idx_c];
    range_err_c = ((addr_q >> ADDR_WIDTH) != 32'd0);
    acc_err_c   = align_err_c | range_err_c;
  end

  lsu_align u_align (
    .we           (we_q),
    .addr_lo      (addr_q[1:0]),
    .funct3       (f3_q),
    .rword        (rword_c),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .mask_c       (mask_c),
    .store_data_c (store_data_c),
    .err_c        (align_err_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          f3_d        = bus.req_funct3;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          cnt_d       = WAIT_INIT;
          state_d     = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        mem_we_c    = we_q & ~acc_err_c;
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err_c;
        rsp_rdata_d = (acc_err_c || we_q) ? 32'd0 : load_data_c;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte-masked array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (mask_c[b]) mem[idx_c][b*8 +: 8] <= store_data_c[b*8 +: 8];
      end
    end
  end

endmodule
